// File: rtl/dio4_mmio_pkg.sv
// Shared definitions for the DIO4 memory-mapped register front end:
// register offsets, CTRL bit positions and the default window base.
package dio4_mmio_pkg;

  localparam int unsigned DIO4_ADDR_W = 16;
  localparam int unsigned DIO4_DATA_W = 16;
  localparam int unsigned DIO4_LED_W  = 8;

  localparam logic [DIO4_ADDR_W-1:0] DIO4_BASE_ADDR_DEFAULT = 16'hFE10;

  typedef enum logic [1:0] {
    DIO4_REG_SSEG   = 2'd0,
    DIO4_REG_LED    = 2'd1,
    DIO4_REG_CTRL   = 2'd2,
    DIO4_REG_STATUS = 2'd3
  } dio4_reg_e;

  localparam int unsigned DIO4_CTRL_COMMIT_BIT = 0;
  localparam int unsigned DIO4_CTRL_AUTO_BIT   = 1;
  localparam int unsigned DIO4_CTRL_MASK_LSB   = 8;

  typedef struct packed {
    logic [DIO4_LED_W-1:0] blink_mask;
    logic                  auto_en;
  } dio4_ctrl_t;

  // CTRL read-back image: COMMIT and unused bits read as zero
  function automatic logic [DIO4_DATA_W-1:0] ctrl_image(input dio4_ctrl_t c);
    logic [DIO4_DATA_W-1:0] v;
    v = '0;
    v[DIO4_CTRL_MASK_LSB +: DIO4_LED_W] = c.blink_mask;
    v[DIO4_CTRL_AUTO_BIT]               = c.auto_en;
    return v;
  endfunction

endpackage

// File: rtl/dio4_mmio_blink_timer.sv
// Prescaled blink phase generator: phase toggles every PRESCALE enabled edges.
module blink_timer #(
  parameter int unsigned PRESCALE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase
);

  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_W'(PRESCALE - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dio4_mmio.sv
// DIO4 register window: shadow/active SSEG and LED registers, CTRL/STATUS,
// blink masking of the LED output and a combinational read-back path.
module dio4_mmio
  import dio4_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DIO4_BASE_ADDR_DEFAULT,
  parameter int unsigned PRESCALE  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic        hit,
  output logic [15:0] rdata,
  output logic [15:0] seven_segment_data,
  output logic [7:0]  led_data,
  output logic        pending
);

  logic [DIO4_DATA_W-1:0] sseg_sh, sseg_act;
  logic [DIO4_LED_W-1:0]  led_sh, led_act;
  dio4_ctrl_t             ctrl;
  logic                   pending_q;
  logic                   phase;
  logic                   wr;
  dio4_reg_e              reg_sel;

  // Window is 4-aligned, so the upper address bits alone decide a hit
  assign hit     = (addr[15:2] == BASE_ADDR[15:2]);
  assign reg_sel = dio4_reg_e'(addr[1:0]);
  assign wr      = we & gwe & hit;

  blink_timer #(
    .PRESCALE(PRESCALE)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (gwe),
    .phase(phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg_sh   <= '0;
      sseg_act  <= '0;
      led_sh    <= '0;
      led_act   <= '0;
      ctrl      <= '0;
      pending_q <= 1'b0;
    end else if (wr) begin
      case (reg_sel)
        DIO4_REG_SSEG: begin
          sseg_sh <= wdata;
          if (ctrl.auto_en) sseg_act  <= wdata;
          else              pending_q <= 1'b1;
        end
        DIO4_REG_LED: begin
          led_sh <= wdata[DIO4_LED_W-1:0];
          if (ctrl.auto_en) led_act   <= wdata[DIO4_LED_W-1:0];
          else              pending_q <= 1'b1;
        end
        DIO4_REG_CTRL: begin
          ctrl.auto_en    <= wdata[DIO4_CTRL_AUTO_BIT];
          ctrl.blink_mask <= wdata[DIO4_CTRL_MASK_LSB +: DIO4_LED_W];
          // Commit takes the shadow values held before this edge
          if (wdata[DIO4_CTRL_COMMIT_BIT]) begin
            sseg_act  <= sseg_sh;
            led_act   <= led_sh;
            pending_q <= 1'b0;
          end
        end
        DIO4_REG_STATUS: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        DIO4_REG_SSEG:   rdata = sseg_sh;
        DIO4_REG_LED:    rdata = {8'b0, led_sh};
        DIO4_REG_CTRL:   rdata = ctrl_image(ctrl);
        DIO4_REG_STATUS: rdata = {14'b0, phase, pending_q};
        default:         rdata = '0;
      endcase
    end
  end

  assign seven_segment_data = sseg_act;
  assign led_data           = led_act & ~(ctrl.blink_mask & {DIO4_LED_W{phase}});
  assign pending            = pending_q;

endmodule

// File: tb/tb_dio4_mmio.sv
// Scoreboard bench for dio4_mmio: stimulus queues expected output values per
// cycle; a negedge monitor pops and compares them against the DUT.
module tb_dio4_mmio;

  localparam logic [15:0] BASE = 16'hFE10;
  localparam int unsigned PS   = 4;

  localparam int K_SSEG = 0;
  localparam int K_LED  = 1;
  localparam int K_PEND = 2;
  localparam int K_HIT  = 3;
  localparam int K_RD   = 4;

  logic        clk = 1'b0;
  logic        rst, gwe, we;
  logic [15:0] addr, wdata;
  logic        hit, pending;
  logic [15:0] rdata, seven_segment_data;
  logic [7:0]  led_data;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   total     = 0;
  int   bad       = 0;
  int   en_edges  = 0;

  dio4_mmio #(
    .BASE_ADDR(BASE),
    .PRESCALE (PS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .gwe               (gwe),
    .addr              (addr),
    .we                (we),
    .wdata             (wdata),
    .hit               (hit),
    .rdata             (rdata),
    .seven_segment_data(seven_segment_data),
    .led_data          (led_data),
    .pending           (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_SSEG:  return "seven_segment_data";
      K_LED:   return "led_data";
      K_PEND:  return "pending";
      K_HIT:   return "hit";
      default: return "rdata";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int k);
    case (k)
      K_SSEG:  return seven_segment_data;
      K_LED:   return {8'b0, led_data};
      K_PEND:  return {15'b0, pending};
      K_HIT:   return {15'b0, hit};
      default: return rdata;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s @cyc %0d: got %h want %h", kname(e.kind), cyc, a, e.val);
      end
    end
  end

  // Expected blink phase: toggles after every PS enabled edges since reset
  function automatic logic exp_phase();
    return 1'((en_edges / PS) % 2);
  endfunction

  function automatic logic [7:0] blink_led(input logic [7:0] act, input logic [7:0] mask);
    return exp_phase() ? (act & ~mask) : act;
  endfunction

  task automatic expect_now(input int k, input logic [15:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic g, input logic w, input logic [15:0] a, input logic [15:0] d);
    gwe   = g;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    if (gwe && !rst) en_edges++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    expect_now(K_SSEG, 16'h0000);
    expect_now(K_LED,  16'h0000);
    expect_now(K_PEND, 16'h0000);
    tick();
    rst = 1'b0;
    en_edges = 0;

    // SSEG store with AUTO=0: shadow only, pending set
    drive(1'b1, 1'b1, BASE, 16'h1234);
    expect_now(K_HIT, 16'h0001);
    expect_now(K_RD,  16'h0000);
    tick();
    drive(1'b1, 1'b0, BASE, 16'h0000);
    expect_now(K_SSEG, 16'h0000);
    expect_now(K_PEND, 16'h0001);
    expect_now(K_RD,   16'h1234);
    tick();
    drive(1'b1, 1'b1, BASE + 16'd2, 16'h0001);
    expect_now(K_RD, 16'h0000);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    expect_now(K_SSEG, 16'h1234);
    expect_now(K_PEND, 16'h0000);
    expect_now(K_RD,   {14'b0, exp_phase(), 1'b0});
    tick();

    // AUTO=1: LED store goes straight to the active copy
    drive(1'b1, 1'b1, BASE + 16'd2, 16'h0002);
    tick();
    drive(1'b1, 1'b1, BASE + 16'd1, 16'h00A5);
    expect_now(K_RD,  16'h0000);
    expect_now(K_LED, 16'h0000);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    expect_now(K_LED,  16'h00A5);
    expect_now(K_PEND, 16'h0000);
    expect_now(K_RD,   16'h00A5);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    expect_now(K_RD, 16'h0002);
    tick();

    // Out-of-window and STATUS stores change nothing
    drive(1'b1, 1'b1, BASE + 16'd4, 16'hFFFF);
    expect_now(K_HIT, 16'h0000);
    expect_now(K_RD,  16'h0000);
    tick();
    drive(1'b1, 1'b1, BASE - 16'd1, 16'hFFFF);
    expect_now(K_HIT, 16'h0000);
    expect_now(K_RD,  16'h0000);
    tick();
    drive(1'b1, 1'b1, BASE + 16'd3, 16'hFFFF);
    tick();
    drive(1'b1, 1'b0, BASE, 16'h0000);
    expect_now(K_RD,   16'h1234);
    expect_now(K_SSEG, 16'h1234);
    expect_now(K_LED,  16'h00A5);
    expect_now(K_PEND, 16'h0000);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    expect_now(K_RD, 16'h0002);
    tick();

    // gwe=0 stores are ignored; pending is held
    drive(1'b1, 1'b1, BASE + 16'd2, 16'h0000);
    tick();
    drive(1'b1, 1'b1, BASE, 16'hBEEF);
    tick();
    drive(1'b0, 1'b1, BASE, 16'h0000);
    expect_now(K_PEND, 16'h0001);
    tick();
    drive(1'b0, 1'b1, BASE + 16'd2, 16'h0003);
    tick();
    drive(1'b0, 1'b1, BASE + 16'd1, 16'h0011);
    tick();
    drive(1'b1, 1'b0, BASE, 16'h0000);
    expect_now(K_PEND, 16'h0001);
    expect_now(K_SSEG, 16'h1234);
    expect_now(K_LED,  16'h00A5);
    expect_now(K_RD,   16'hBEEF);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    expect_now(K_RD, 16'h00A5);
    tick();

    // Blink: active LED FF, mask F0, commit in the same CTRL write
    drive(1'b1, 1'b1, BASE + 16'd1, 16'h00FF);
    tick();
    drive(1'b1, 1'b1, BASE + 16'd2, 16'hF001);
    tick();
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      expect_now(K_LED,  {8'b0, blink_led(8'hFF, 8'hF0)});
      expect_now(K_SSEG, 16'hBEEF);
      expect_now(K_RD,   {14'b0, exp_phase(), 1'b0});
      tick();
    end
    gwe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_now(K_LED, {8'b0, blink_led(8'hFF, 8'hF0)});
      tick();
    end
    gwe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_now(K_LED, {8'b0, blink_led(8'hFF, 8'hF0)});
      tick();
    end

    // Setting AUTO does not flush a pending shadow
    drive(1'b1, 1'b1, BASE, 16'h5555);
    tick();
    drive(1'b1, 1'b1, BASE + 16'd2, 16'hF002);
    expect_now(K_PEND, 16'h0001);
    tick();
    drive(1'b1, 1'b1, BASE, 16'h6666);
    expect_now(K_SSEG, 16'hBEEF);
    expect_now(K_PEND, 16'h0001);
    tick();
    drive(1'b1, 1'b0, BASE, 16'h0000);
    expect_now(K_SSEG, 16'h6666);
    expect_now(K_PEND, 16'h0001);
    tick();

    // Reset mid-blink while phase=1 clears outputs before the next edge
    guard = 0;
    while (!exp_phase() && guard < 3 * PS) begin
      tick();
      guard++;
    end
    total++;
    if (!exp_phase()) begin
      bad++;
      $display("FAIL phase_wait: got phase 0 want 1");
    end
    expect_now(K_LED, {8'b0, blink_led(8'hFF, 8'hF0)});
    tick();
    rst = 1'b1;
    en_edges = 0;
    expect_now(K_SSEG, 16'h0000);
    expect_now(K_LED,  16'h0000);
    expect_now(K_PEND, 16'h0000);
    expect_now(K_RD,   16'h0000);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      expect_now(K_RD, {14'b0, exp_phase(), 1'b0});
      tick();
    end

    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
